mm2s_readback: RTL and testbench



---
 rtl/dso_dm_pkg.sv | 45 ++++
 rtl/mm2s_readback.sv | 176 +++++++++++++++++
 tb/tb_mm2s_readback.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dso_dm_pkg.sv
// DataMover command/status field layout and readback FSM states.
// Shared by the MM2S readback engine and the S2MM capture path.
package dso_dm_pkg;

   localparam int CMD_W          = 72;
   localparam int CMD_BTT_LSB    = 0;
   localparam int CMD_BTT_W      = 23;
   localparam int CMD_TYPE_BIT   = 23;
   localparam int CMD_EOF_BIT    = 30;
   localparam int CMD_SADDR_LSB  = 32;
   localparam int CMD_SADDR_W    = 32;
   localparam int CMD_TAG_LSB    = 64;
   localparam int TAG_W          = 4;

   localparam int STS_TAG_LSB    = 0;
   localparam int STS_INTERR_BIT = 4;
   localparam int STS_DECERR_BIT = 5;
   localparam int STS_SLVERR_BIT = 6;
   localparam int STS_OKAY_BIT   = 7;

   typedef enum logic [2:0] {
      RB_IDLE,
      RB_CMD,
      RB_DATA,
      RB_STS,
      RB_FIN
   } rb_state_e;

   // INCR burst, EOF set, DRR/DSA and reserved fields left at zero.
   function automatic logic [CMD_W-1:0] build_cmd(
      input logic [CMD_SADDR_W-1:0] addr,
      input logic [CMD_BTT_W-1:0]   len,
      input logic [TAG_W-1:0]       tag
   );
      logic [CMD_W-1:0] cmd;
      cmd                                = '0;
      cmd[CMD_BTT_LSB +: CMD_BTT_W]      = len;
      cmd[CMD_TYPE_BIT]                  = 1'b1;
      cmd[CMD_EOF_BIT]                   = 1'b1;
      cmd[CMD_SADDR_LSB +: CMD_SADDR_W]  = addr;
      cmd[CMD_TAG_LSB +: TAG_W]          = tag;
      return cmd;
   endfunction

endpackage

// File: rtl/mm2s_readback.sv
// Capture-memory readback: splits a transfer into DataMover MM2S commands,
// forwards the read stream downstream and checks every status word.
module mm2s_readback
   import dso_dm_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int BTT_W       = 23,
   parameter int CHUNK_BYTES = 4096,
   parameter int DATA_W      = 128
)(
   input  logic              axi_aclk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [31:0]       total_bytes,
   output logic [71:0]       cmd_tdata,
   output logic              cmd_tvalid,
   input  logic              cmd_tready,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   input  logic              s_tlast,
   output logic              s_tready,
   input  logic [7:0]        sts_tdata,
   input  logic              sts_tvalid,
   output logic              sts_tready,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   output logic              m_tlast,
   input  logic              m_tready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [15:0]       chunks_done
);

   localparam int          BEAT_W    = BTT_W - 4;
   localparam logic [31:0] CHUNK_LEN = 32'(CHUNK_BYTES);

   rb_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       rem_q, rem_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [BEAT_W-1:0] beats_q, beats_d;
   logic [15:0]       chunks_q, chunks_d;
   logic              err_q, err_d;
   logic              drain_q, drain_d;
   logic              done_q;

   logic [31:0]       len;
   logic              lastBeat;
   logic              draining;
   logic              stsBad;
   logic              unusedTotalLsbs;

   assign unusedTotalLsbs = ^total_bytes[3:0];
   assign len       = (rem_q > CHUNK_LEN) ? CHUNK_LEN : rem_q;
   assign lastBeat  = (beats_q == BEAT_W'(1));
   assign draining  = drain_q | abort;
   assign stsBad    = !sts_tdata[STS_OKAY_BIT] | sts_tdata[STS_SLVERR_BIT]
                    | sts_tdata[STS_DECERR_BIT] | sts_tdata[STS_INTERR_BIT]
                    | (sts_tdata[STS_TAG_LSB +: TAG_W] != tag_q);

   // Command depends only on registers, so it stays stable while stalled.
   assign cmd_tdata   = build_cmd(CMD_SADDR_W'(addr_q), len[CMD_BTT_W-1:0], tag_q);
   assign m_tdata     = s_tdata;
   assign busy        = (state_q != RB_IDLE);
   assign done        = done_q;
   assign err         = err_q;
   assign chunks_done = chunks_q;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      tag_d      = tag_q;
      beats_d    = beats_q;
      chunks_d   = chunks_q;
      err_d      = err_q;
      drain_d    = drain_q;
      cmd_tvalid = 1'b0;
      s_tready   = 1'b0;
      sts_tready = 1'b0;
      m_tvalid   = 1'b0;
      m_tlast    = 1'b0;
      case (state_q)
         RB_IDLE: begin
            if (start) begin
               addr_d   = base_addr;
               rem_d    = {total_bytes[31:4], 4'b0000};
               tag_d    = '0;
               chunks_d = '0;
               err_d    = 1'b0;
               drain_d  = 1'b0;
               state_d  = (total_bytes[31:4] == '0) ? RB_FIN : RB_CMD;
            end
         end
         RB_CMD: begin
            if (abort) begin
               state_d = RB_FIN;
            end else begin
               cmd_tvalid = 1'b1;
               if (cmd_tready) begin
                  beats_d = len[BTT_W-1:4];
                  addr_d  = addr_q + ADDR_W'(len);
                  rem_d   = rem_q - len;
                  state_d = RB_DATA;
               end
            end
         end
         // Once aborted, the rest of the chunk is accepted and discarded.
         RB_DATA: begin
            s_tready = draining ? 1'b1 : m_tready;
            m_tvalid = draining ? 1'b0 : s_tvalid;
            m_tlast  = lastBeat && (rem_q == '0) && !draining;
            drain_d  = draining;
            if (s_tvalid && s_tready) begin
               if (s_tlast != lastBeat) begin
                  err_d = 1'b1;
               end
               beats_d = beats_q - BEAT_W'(1);
               if (lastBeat) begin
                  state_d = RB_STS;
               end
            end
         end
         RB_STS: begin
            sts_tready = 1'b1;
            if (sts_tvalid) begin
               if (stsBad) begin
                  err_d = 1'b1;
               end else begin
                  chunks_d = (chunks_q == 16'hFFFF) ? chunks_q : chunks_q + 16'd1;
                  tag_d    = tag_q + TAG_W'(1);
               end
               if (stsBad || err_q || draining || (rem_q == '0)) begin
                  state_d = RB_FIN;
               end else begin
                  state_d = RB_CMD;
               end
            end
         end
         RB_FIN: begin
            state_d = RB_IDLE;
         end
         default: begin
            state_d = RB_IDLE;
         end
      endcase
   end

   always_ff @(posedge axi_aclk) begin
      if (rst) begin
         state_q  <= RB_IDLE;
         addr_q   <= '0;
         rem_q    <= '0;
         tag_q    <= '0;
         beats_q  <= '0;
         chunks_q <= '0;
         err_q    <= 1'b0;
         drain_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         tag_q    <= tag_d;
         beats_q  <= beats_d;
         chunks_q <= chunks_d;
         err_q    <= err_d;
         drain_q  <= drain_d;
         done_q   <= (state_q == RB_FIN);
      end
   end

endmodule

// File: tb/tb_mm2s_readback.sv
// Directed bench for mm2s_readback: the bench plays the DataMover MM2S side
// and the downstream consumer, with hand-computed commands, beats and flags.
module tb_mm2s_readback;

   logic         axi_aclk;
   logic         rst;
   logic         start;
   logic         abort;
   logic [31:0]  base_addr;
   logic [31:0]  total_bytes;
   logic [71:0]  cmd_tdata;
   logic         cmd_tvalid;
   logic         cmd_tready;
   logic [127:0] s_tdata;
   logic         s_tvalid;
   logic         s_tlast;
   logic         s_tready;
   logic [7:0]   sts_tdata;
   logic         sts_tvalid;
   logic         sts_tready;
   logic [127:0] m_tdata;
   logic         m_tvalid;
   logic         m_tlast;
   logic         m_tready;
   logic         busy;
   logic         done;
   logic         err;
   logic [15:0]  chunks_done;

   int nTests = 0;
   int nFail  = 0;
   int mBeats = 0;
   bit sawCmd = 0;

   mm2s_readback #(
      .ADDR_W(32), .BTT_W(23), .CHUNK_BYTES(4096), .DATA_W(128)
   ) dut (
      .axi_aclk(axi_aclk), .rst(rst), .start(start), .abort(abort),
      .base_addr(base_addr), .total_bytes(total_bytes),
      .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .sts_tdata(sts_tdata), .sts_tvalid(sts_tvalid), .sts_tready(sts_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .busy(busy), .done(done), .err(err), .chunks_done(chunks_done)
   );

   initial axi_aclk = 1'b0;
   always #5 axi_aclk = ~axi_aclk;

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      nTests++;
      assert (observed === expected) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Called one step after a rising edge; start is sampled at the next edge.
   task automatic applyStimulus(input logic [31:0] base, input logic [31:0] total);
      mBeats      = 0;
      base_addr   = base;
      total_bytes = total;
      start       = 1'b1;
      @(posedge axi_aclk); #1;
      start       = 1'b0;
   endtask

   task automatic expectCmd(input logic [31:0] addr, input logic [22:0] len,
                            input logic [3:0] tag, input int stallCycles);
      logic [71:0] expCmd;
      int waitCnt = 0;
      expCmd = {4'h0, tag, addr, 1'b0, 1'b1, 6'h00, 1'b1, len};
      while (cmd_tvalid !== 1'b1 && waitCnt < 20) begin
         @(posedge axi_aclk); #1;
         waitCnt++;
      end
      checkOutput("cmd_tvalid", cmd_tvalid, 1'b1);
      for (int k = 0; k < stallCycles; k++) begin
         checkOutput("cmd_stall_stable", cmd_tdata, expCmd);
         @(posedge axi_aclk); #1;
      end
      checkOutput("cmd_tdata", cmd_tdata, expCmd);
      cmd_tready = 1'b1;
      @(posedge axi_aclk); #1;
      cmd_tready = 1'b0;
   endtask

   task automatic streamChunk(input int nBeats, input int tlastAt, input int abortAt,
                              input bit lastChunk, input bit randomReady,
                              input logic [7:0] chunkId);
      int i = 0;
      int cycles = 0;
      bit draining = 0;
      logic expReady;
      logic [127:0] beatData;
      while (i < nBeats && cycles < 4 * nBeats + 50) begin
         if (i == abortAt) begin
            abort    = 1'b1;
            draining = 1'b1;
         end
         beatData = {chunkId, 24'(i), 32'hCAFE_F00D, ~32'(i), 32'(i * 7)};
         s_tdata  = beatData;
         s_tvalid = 1'b1;
         s_tlast  = (i == tlastAt);
         m_tready = randomReady ? 1'($urandom_range(0, 1)) : !draining;
         #1;
         expReady = draining ? 1'b1 : m_tready;
         checkOutput("s_tready", s_tready, expReady);
         checkOutput("m_tvalid", m_tvalid, !draining);
         if (!draining) begin
            checkOutput("m_tdata", m_tdata, beatData);
            checkOutput("m_tlast", m_tlast, lastChunk && (i == nBeats - 1));
         end
         if (i == 0) checkOutput("sts_held_off", sts_tready, 1'b0);
         if (m_tvalid === 1'b1 && m_tready === 1'b1) mBeats++;
         if (expReady) i++;
         cycles++;
         @(posedge axi_aclk); #1;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      m_tready = 1'b0;
      checkOutput("stream_beats", i, nBeats);
   endtask

   task automatic sendStatus(input logic [7:0] sts);
      int waitCnt = 0;
      while (sts_tready !== 1'b1 && waitCnt < 20) begin
         @(posedge axi_aclk); #1;
         waitCnt++;
      end
      checkOutput("sts_tready", sts_tready, 1'b1);
      sts_tdata  = sts;
      sts_tvalid = 1'b1;
      @(posedge axi_aclk); #1;
      sts_tvalid = 1'b0;
   endtask

   task automatic waitDone();
      int cnt = 0;
      sawCmd = 0;
      while (done !== 1'b1 && cnt < 20) begin
         if (cmd_tvalid === 1'b1) sawCmd = 1;
         @(posedge axi_aclk); #1;
         cnt++;
      end
      checkOutput("done", done, 1'b1);
      checkOutput("busy_at_done", busy, 1'b0);
      @(posedge axi_aclk); #1;
      checkOutput("done_one_cycle", done, 1'b0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; total_bytes = '0;
      cmd_tready = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
      sts_tdata = '0; sts_tvalid = 1'b0; m_tready = 1'b0;
      repeat (3) @(posedge axi_aclk);
      #1;
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_err", err, 1'b0);
      checkOutput("rst_cmd_tvalid", cmd_tvalid, 1'b0);
      checkOutput("rst_s_tready", s_tready, 1'b0);
      checkOutput("rst_sts_tready", sts_tready, 1'b0);
      checkOutput("rst_m_tvalid", m_tvalid, 1'b0);
      checkOutput("rst_m_tlast", m_tlast, 1'b0);
      checkOutput("rst_chunks", chunks_done, 16'd0);
      rst = 1'b0;
      @(posedge axi_aclk); #1;

      $display("[TB] two chunks from 0x1000, start pulse while busy");
      applyStimulus(32'h0000_1000, 32'd8192);
      checkOutput("t1_busy", busy, 1'b1);
      expectCmd(32'h0000_1000, 23'd4096, 4'd0, 0);
      base_addr = 32'hDEAD_0000; total_bytes = 32'd64; start = 1'b1;
      @(posedge axi_aclk); #1;
      start = 1'b0;
      streamChunk(256, 255, -1, 1'b0, 1'b0, 8'h10);
      sendStatus(8'h80);
      expectCmd(32'h0000_2000, 23'd4096, 4'd1, 0);
      streamChunk(256, 255, -1, 1'b1, 1'b0, 8'h11);
      sendStatus(8'h81);
      waitDone();
      checkOutput("t1_beats", mBeats, 512);
      checkOutput("t1_chunks", chunks_done, 16'd2);
      checkOutput("t1_err", err, 1'b0);
      checkOutput("t1_no_extra_cmd", sawCmd, 1'b0);

      $display("[TB] 4100 bytes rounds down to one chunk");
      applyStimulus(32'h0004_0000, 32'd4100);
      expectCmd(32'h0004_0000, 23'd4096, 4'd0, 0);
      streamChunk(256, 255, -1, 1'b1, 1'b0, 8'h20);
      sendStatus(8'h80);
      waitDone();
      checkOutput("t2_beats", mBeats, 256);
      checkOutput("t2_chunks", chunks_done, 16'd1);
      checkOutput("t2_no_extra_cmd", sawCmd, 1'b0);

      $display("[TB] zero-length transfer");
      applyStimulus(32'h0000_0000, 32'd0);
      checkOutput("t3_cmd_c1", cmd_tvalid, 1'b0);
      checkOutput("t3_done_c1", done, 1'b0);
      checkOutput("t3_busy_c1", busy, 1'b1);
      @(posedge axi_aclk); #1;
      checkOutput("t3_done_c2", done, 1'b1);
      checkOutput("t3_busy_c2", busy, 1'b0);
      checkOutput("t3_cmd_c2", cmd_tvalid, 1'b0);
      @(posedge axi_aclk); #1;
      checkOutput("t3_done_c3", done, 1'b0);
      checkOutput("t3_busy_c3", busy, 1'b0);

      $display("[TB] SLVERR status on chunk 2 of 3");
      applyStimulus(32'h0000_3000, 32'd12288);
      expectCmd(32'h0000_3000, 23'd4096, 4'd0, 0);
      streamChunk(256, 255, -1, 1'b0, 1'b0, 8'h30);
      sendStatus(8'h80);
      expectCmd(32'h0000_4000, 23'd4096, 4'd1, 0);
      streamChunk(256, 255, -1, 1'b0, 1'b0, 8'h31);
      sendStatus(8'h41);
      waitDone();
      checkOutput("t4_err", err, 1'b1);
      checkOutput("t4_chunks", chunks_done, 16'd1);
      checkOutput("t4_no_third_cmd", sawCmd, 1'b0);

      $display("[TB] new start clears sticky error");
      applyStimulus(32'h0000_0000, 32'd8);
      checkOutput("t5_err_cleared", err, 1'b0);
      checkOutput("t5_chunks_cleared", chunks_done, 16'd0);
      waitDone();

      $display("[TB] backpressure, command stall and address wrap");
      applyStimulus(32'hFFFF_F000, 32'd12288);
      expectCmd(32'hFFFF_F000, 23'd4096, 4'd0, 3);
      streamChunk(256, 255, -1, 1'b0, 1'b1, 8'h60);
      sendStatus(8'h80);
      expectCmd(32'h0000_0000, 23'd4096, 4'd1, 2);
      streamChunk(256, 255, -1, 1'b0, 1'b1, 8'h61);
      sendStatus(8'h81);
      expectCmd(32'h0000_1000, 23'd4096, 4'd2, 0);
      streamChunk(256, 255, -1, 1'b1, 1'b1, 8'h62);
      sendStatus(8'h82);
      waitDone();
      checkOutput("t6_beats", mBeats, 768);
      checkOutput("t6_chunks", chunks_done, 16'd3);
      checkOutput("t6_err", err, 1'b0);

      $display("[TB] abort at beat 10 of chunk 1 of 3");
      applyStimulus(32'h0000_8000, 32'd12288);
      expectCmd(32'h0000_8000, 23'd4096, 4'd0, 0);
      streamChunk(256, 255, 10, 1'b0, 1'b0, 8'h70);
      sendStatus(8'h80);
      abort = 1'b0;
      waitDone();
      checkOutput("t7_beats", mBeats, 10);
      checkOutput("t7_no_chunk2_cmd", sawCmd, 1'b0);
      checkOutput("t7_chunks", chunks_done, 16'd1);
      checkOutput("t7_err", err, 1'b0);

      $display("[TB] early s_tlast at beat 100");
      applyStimulus(32'h0000_A000, 32'd4096);
      expectCmd(32'h0000_A000, 23'd4096, 4'd0, 0);
      streamChunk(256, 100, -1, 1'b1, 1'b0, 8'h80);
      sendStatus(8'h80);
      waitDone();
      checkOutput("t8_err", err, 1'b1);

      $display("[TB] reset in the middle of a transfer");
      applyStimulus(32'h0001_0000, 32'd8192);
      expectCmd(32'h0001_0000, 23'd4096, 4'd0, 0);
      s_tvalid = 1'b1; m_tready = 1'b1; rst = 1'b1;
      @(posedge axi_aclk); #1;
      checkOutput("t9_busy", busy, 1'b0);
      checkOutput("t9_s_tready", s_tready, 1'b0);
      checkOutput("t9_m_tvalid", m_tvalid, 1'b0);
      rst = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
      @(posedge axi_aclk); #1;

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
